pong_writer: RTL and testbench
==============================

Name: pong_writer

Overview:
- Write-side initiator for the init/wr/addr/data/busy memory handshake; the counterpart to the existing read initiator that drives the same interface.
- On start, accepts ARR_LENGTH words from a valid/ready stream and writes them to consecutive addresses of the delayed-response memory, beginning at base_addr.
- Sits between a data producer (e.g. matrix result path) and the memory responder; one transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 8, width of address bus and base_addr
ARR_LENGTH, 8, words written per start; legal range 1..2^ADDR_WIDTH
DATA_WIDTH, 8, width of write data
TIMEOUT, 16, max cycles to wait for mem_busy to rise after init before flagging error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a burst; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first write address; latched on accepted start
s_valid  in  1  producer has a word
s_data  in  DATA_WIDTH  producer word
s_ready  out  1  block accepts s_data this cycle
mem_busy  in  1  responder busy
init_out  out  1  one-cycle transaction request
wr_out  out  1  write qualifier; high with every request this block issues
addr_out  out  ADDR_WIDTH  transaction address
data_out  out  DATA_WIDTH  write data
active  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
err  out  1  sticky timeout flag; cleared by next accepted start or reset

Behaviour:
- Reset (async, any state): state IDLE; init_out, wr_out, s_ready, active, done, err = 0; addr_out, data_out, index counter = 0. Reset mid-burst abandons the burst; no further init is issued.
- States: IDLE, GET, ISSUE, WAIT_HI, WAIT_LO, FIN.
- IDLE: start=1 -> latch base_addr, index=0, clear err, go GET. start in any other state is ignored.
- GET: s_ready=1. s_valid=1 -> capture s_data into data_out, addr_out = base + index (mod 2^ADDR_WIDTH, wraps silently), go ISSUE. No capture without s_valid.
- ISSUE: if mem_busy=0, assert init_out=1 and wr_out=1 for exactly this cycle, go WAIT_HI; otherwise hold in ISSUE with init_out=0.
- WAIT_HI: waits for mem_busy=1; timeout counter starts at 0. If it reaches TIMEOUT cycles, set err, go FIN.
- WAIT_LO: on mem_busy=0 (falling edge of busy = write complete): if index == ARR_LENGTH-1, go FIN; else index++, go GET.
- FIN: done=1 for one cycle, go IDLE.
- addr_out and data_out are stable from ISSUE until the next capture in GET; no change while mem_busy=1.
- active = 1 in every state except IDLE.
- Minimum per-word cost against a CYCLES-latency responder: 1 (GET) + 1 (ISSUE) + CYCLES + 1 cycles.
- Index width: clog2(ARR_LENGTH)+1 bits; address arithmetic is truncated to ADDR_WIDTH.

Test Plan:
- Basic burst: CYCLES=2, ARR_LENGTH=8, base_addr=0x10, s_valid held high with s_data=0xA0+n -> memory 0x10..0x17 = 0xA0..0xA7; exactly 8 init pulses, all with wr_out=1; one done pulse; err=0.
- Wrap: base_addr=0xFC, ARR_LENGTH=8 -> writes land at 0xFC..0xFF, then 0x00..0x03; no write outside these addresses.
- Producer stall: s_valid low for 5 cycles before word 3 -> s_ready stays high through the gap; no init during the gap; data order is preserved.
- Busy-held start: mem_busy forced high for 4 cycles when the block enters ISSUE -> init_out stays 0 until the cycle mem_busy is 0, then pulses once.
- Timeout: responder disconnected (mem_busy tied 0), TIMEOUT=16 -> err=1 and done pulses 16 cycles after init. A later start clears err and completes normally.
- Async reset mid-burst: assert rst after word 4 write, between clock edges -> all outputs go to 0 immediately. After release, no init occurs until a new start.

Source files
------------

// File: rtl/pong_writer_if.sv
// Stream-in and memory-request signals of the pong write initiator.
// master = the writer; slave = producer plus memory responder side.
interface pong_writer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  mem_busy;
  logic                  init_out;
  logic                  wr_out;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  s_valid, s_data, mem_busy,
    output s_ready, init_out, wr_out, addr_out, data_out
  );

  modport slave (
    output s_valid, s_data, mem_busy,
    input  s_ready, init_out, wr_out, addr_out, data_out
  );
endinterface

// File: rtl/pong_writer.sv
// Write initiator: pulls ARR_LENGTH words from a valid/ready stream and writes
// them to consecutive addresses through the init/wr/addr/data/busy handshake.
module pong_writer #(
  parameter int ADDR_WIDTH = 8,
  parameter int ARR_LENGTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  pong_writer_if.master         bus,
  output logic                  active,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = $clog2(ARR_LENGTH) + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GET, ISSUE, WAIT_HI, WAIT_LO, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q,  base_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  err_q,   err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = GET;
        end
      end
      GET: begin
        if (bus.s_valid) begin
          data_d  = bus.s_data;
          addr_d  = base_q + ADDR_WIDTH'(idx_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The counter measures cycles since init, so the init cycle counts as 0
        // and WAIT_HI is entered with one cycle already elapsed.
        if (!bus.mem_busy) begin
          cnt_d   = CNT_W'(1);
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.mem_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.mem_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = GET;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready  = (state_q == GET);
    bus.init_out = (state_q == ISSUE) && !bus.mem_busy;
    bus.wr_out   = (state_q == ISSUE) && !bus.mem_busy;
    bus.addr_out = addr_q;
    bus.data_out = data_q;
    active       = (state_q != IDLE);
    done         = (state_q == FIN);
    err          = err_q;
  end

endmodule

// File: tb/tb_pong_writer.sv
// Randomized scoreboard bench for pong_writer against a delayed-busy memory model.
module tb_pong_writer;
  localparam int AW     = 8;
  localparam int AL     = 8;
  localparam int DW     = 8;
  localparam int TO     = 16;
  localparam int CYCLES = 2;

  typedef struct {logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic e; int delta;} done_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          active, done, err;

  pong_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  pong_writer #(.ADDR_WIDTH(AW), .ARR_LENGTH(AL), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bus(bus), .active(active), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_init   = 0;
  int n_done   = 0;
  int last_init_cyc = 0;
  wr_t   exp_wr[$];
  done_t exp_done[$];
  logic [7:0] bw[AL];

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Memory responder: busy for CYCLES cycles after each accepted write request.
  logic       busy_r = 1'b0;
  logic       force_busy = 1'b0;
  logic       connected = 1'b1;
  logic       mem_clr = 1'b0;
  int         resp_left = 0;
  logic [7:0] mem[256];
  int         wr_cnt[256];

  assign bus.mem_busy = busy_r | force_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) wr_cnt[i] <= 0;
    end else if (resp_left != 0) begin
      resp_left <= resp_left - 1;
      if (resp_left == 1) busy_r <= 1'b0;
    end else if (bus.init_out && bus.wr_out && connected) begin
      busy_r    <= 1'b1;
      resp_left <= CYCLES;
      mem[bus.addr_out]    <= bus.data_out;
      wr_cnt[bus.addr_out] <= wr_cnt[bus.addr_out] + 1;
    end
  end

  // Monitor: pops expectations whenever the DUT issues a request or ends a burst.
  wr_t   mw;
  done_t md;
  logic [7:0] held_a = '0, held_d = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.init_out) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_init", 1, 0);
        end else begin
          mw = exp_wr.pop_front();
          check("init_addr", bus.addr_out, mw.a);
          check("init_data", bus.data_out, mw.d);
          check("init_wr", bus.wr_out, 1);
        end
        held_a = bus.addr_out;
        held_d = bus.data_out;
        last_init_cyc = cyc;
        n_init++;
      end
      if (busy_r && active) begin
        check("busy_addr_hold", bus.addr_out, held_a);
        check("busy_data_hold", bus.data_out, held_d);
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          md = exp_done.pop_front();
          check("done_err", err, md.e);
          if (md.delta >= 0) check("done_latency", cyc - last_init_cyc, md.delta);
        end
        n_done++;
      end
    end
  end

  task automatic clear_mem();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    check("err_clear_on_start", err, 0);
    check("active_after_start", active, 1);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.s_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check("s_ready_wait_expired", 0, 1);
  endtask

  task automatic wait_done(input int d0);
    bit seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (n_done > d0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_mem(input logic [7:0] b, input string nm);
    int bad = 0;
    logic [7:0] off;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 256; a++) begin
      off = 8'(a - int'(b));
      if (int'(off) < AL) begin
        if (wr_cnt[a] != 1 || mem[a] !== bw[off]) bad++;
      end else if (wr_cnt[a] != 0) begin
        bad++;
      end
    end
    check(nm, bad, 0);
  endtask

  task automatic burst(input logic [7:0] b, input int stall_idx, input int force_idx,
                       input int abort_idx, input bit incr_data);
    bit ok;
    logic [7:0] w;
    int i0 = n_init;
    int d0 = n_done;
    if (abort_idx < 0) exp_done.push_back('{1'b0, -1});
    do_start(b);
    for (int i = 0; i < AL; i++) begin
      w = incr_data ? 8'(8'hA0 + i) : 8'($urandom);
      bw[i] = w;
      if (i == abort_idx) begin
        bus.s_valid = 1'b0;
        wait_ready(ok);
        #2 rst = 1'b1;
        #1;
        check("rst_init", bus.init_out, 0);
        check("rst_wr", bus.wr_out, 0);
        check("rst_ready", bus.s_ready, 0);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_addr", bus.addr_out, 0);
        check("rst_data", bus.data_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
          @(negedge clk);
          check("post_rst_no_init", bus.init_out, 0);
        end
        check("post_rst_idle", active, 0);
        check("post_rst_init_count", n_init - i0, abort_idx);
        check("post_rst_queue_empty", exp_wr.size(), 0);
        return;
      end
      if (i == stall_idx) begin
        bus.s_valid = 1'b0;
        wait_ready(ok);
        repeat (5) begin
          check("stall_ready_high", bus.s_ready, 1);
          check("stall_no_init", bus.init_out, 0);
          @(negedge clk);
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      wait_ready(ok);
      if (!ok) return;
      exp_wr.push_back('{8'(int'(b) + i), w});
      @(posedge clk); #1;
      if (i == force_idx) begin
        force_busy = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("busy_held_no_init", bus.init_out, 0);
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
        #1 check("init_after_release", bus.init_out, 1);
      end
    end
    bus.s_valid = 1'b0;
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("init_count", n_init - i0, AL);
    check("done_count", n_done - d0, 1);
    check("err_after_burst", err, 0);
  endtask

  initial begin
    bit ok;
    logic [7:0] w;
    int d0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_active", active, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_ready", bus.s_ready, 0);
    check("reset_init", bus.init_out, 0);
    check("reset_addr", bus.addr_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    clear_mem(); burst(8'h10, -1, -1, -1, 1'b1); check_mem(8'h10, "mem_basic");
    clear_mem(); burst(8'hFC, -1, -1, -1, 1'b0); check_mem(8'hFC, "mem_wrap");
    clear_mem(); burst(8'h30,  3, -1, -1, 1'b0); check_mem(8'h30, "mem_stall");
    clear_mem(); burst(8'h50, -1,  0, -1, 1'b0); check_mem(8'h50, "mem_busy_held");

    // Responder disconnected: busy never rises, so the first request times out.
    connected = 1'b0;
    d0 = n_done;
    exp_done.push_back('{1'b1, TO});
    do_start(8'h40);
    w = 8'($urandom);
    bus.s_valid = 1'b1; bus.s_data = w;
    wait_ready(ok);
    exp_wr.push_back('{8'h40, w});
    @(posedge clk); #1 bus.s_valid = 1'b0;
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    check("idle_after_timeout", active, 0);
    connected = 1'b1;
    clear_mem(); burst(8'h60, -1, -1, -1, 1'b0); check_mem(8'h60, "mem_after_timeout");

    for (int r = 0; r < 3; r++) begin
      logic [7:0] b = 8'($urandom);
      clear_mem();
      burst(b, int'($urandom_range(0, AL)), -1, -1, 1'b0);
      check_mem(b, "mem_random");
    end

    burst(8'h80, -1, -1, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
